counter_share_sched: RTL and testbench
======================================

Name: counter_share_sched

Overview:
- Round-robin scheduler that shares one saturating interval counter among NREQ requesters.
- Each requester presents its own terminal count. The scheduler grants the counter to one requester, loads that terminal count, and runs the counter from 0 up to the terminal count.
- On completion it pulses that requester's done line.
- Sits between the timing consumers and the shared counter datapath, so each consumer does not need its own counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 8, counter and limit width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset.
- req  input  NREQ  per-requester request, level; must be held until done.
- limit_in  input  NREQ*CW  packed terminal counts; requester i uses bits [i*CW +: CW].
- grant  output  NREQ  one-hot owner of the counter; all-zero when idle.
- done  output  NREQ  one-cycle completion pulse to the owning requester.
- count  output  CW  current counter value.
- busy  output  1  high in RUN and DONE states.

Behaviour:
- Reset: rst is synchronous, active-high.
  - Reset values: state=IDLE, grant=0, done=0, count=0, busy=0, rr pointer=0, latched limit=0.
  - Reset mid-operation abandons the current grant with no done pulse.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - If any req bit is set, pick the winner by scanning from the rr pointer upward, wrapping modulo NREQ.
  - Register: grant=onehot(winner), lim=limit_in slice of winner, count=0. Go to RUN.
  - If req==0, stay in IDLE with outputs unchanged.
- RUN:
  - If count==lim, go to DONE.
  - Otherwise count<=count+1.
  - count never wraps, because the maximum lim is 2^CW-1.
  - limit_in changes after the grant are ignored; lim is latched.
- DONE:
  - done[winner]=1 for exactly this cycle; grant is still held this cycle.
  - Next edge: grant=0, rr pointer=(winner+1) mod NREQ, state=IDLE.
  - count holds its final value until the next grant.
- Timing: for a request sampled at edge E0:
  - grant high after E0.
  - count reaches lim after edge E0+lim.
  - DONE entered at E0+lim+1; done is high between E0+lim+1 and E0+lim+2.
  - Back in IDLE after E0+lim+2.
  - Total occupancy is lim+2 cycles. The next grant can occur at the earliest at E0+lim+3.
- limit=0: one RUN cycle with count=0, then DONE.
- Fairness: a requester that keeps req high is re-granted only after every other pending requester has been served once.
- Simultaneous requests arriving in IDLE are resolved by the rr pointer only; there is no fixed priority.
- Requests that arrive during RUN or DONE are held off until IDLE.
- grant is always one-hot or zero. done is a subset of grant.

Optional Feature:
- Macro: COUNTER_SCHED_ABORT_EN.
- Defined:
  - In RUN, if req[winner] is sampled low, go directly to IDLE next edge: grant=0, no done pulse, rr pointer advances past winner.
  - count holds its last value.
- Undefined:
  - req is ignored after the grant; the interval always runs to completion and pulses done.

Test Plan:
- Reset: assert rst 2 cycles during a RUN with count=5 -> grant=0, done=0, count=0, busy=0, state IDLE on the next edge.
- Single request: req=0001, limit0=3 -> grant=0001 for 5 cycles, count 0,1,2,3,3, done[0] pulses in the 5th cycle only, busy low afterwards.
- Round-robin: req=1111 held continuously, all limits=0 -> grants in order 0001,0010,0100,1000,0001, each spanning 2 cycles with 1 IDLE cycle between grants.
- Saturation edge: limit1=255, CW=8 -> count reaches 255, never wraps to 0, done[1] pulses once, 257 grant cycles total.
- Limit latch: limit2=4 at grant, changed to 1 during RUN -> count still reaches 4 before done[2].
- Abort:
  - With COUNTER_SCHED_ABORT_EN: drop req[0] at count=2 -> grant clears, no done, next grant goes to requester 1 if pending.
  - Without the macro: same stimulus -> runs to completion and done[0] pulses.

Source files
------------

// File: rtl/counter_share_sched.sv
// counter_share_sched: round-robin scheduler that lends one shared interval
// counter to NREQ requesters. The winner's terminal count is latched at grant
// time, the counter runs 0..lim, then the owner gets a one-cycle done pulse.
// Optional build macro COUNTER_SCHED_ABORT_EN: the owner dropping req while
// the counter runs releases the grant early with no done pulse.
module counter_share_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] limit_in,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [CW-1:0]      count,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [CW-1:0]  count_n;
  logic [CW-1:0]  lim, lim_n;
  logic [PW-1:0]  rr, rr_n;
  logic [PW-1:0]  win, win_n;
  logic [PW-1:0]  next_ptr;
  logic [PW-1:0]  scan;
  logic [PW-1:0]  pick;
  logic           found;

  // Scan requests starting at the round-robin pointer, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = PW'((int'(rr) + k) % NREQ);
      if (!found && req[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // Pointer value that places the current owner last in line
  always_comb begin
    next_ptr = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
  end

  // Next-state and next-register values for the IDLE/RUN/DONE sequence
  always_comb begin
    state_n = state;
    grant_n = grant;
    count_n = count;
    lim_n   = lim;
    rr_n    = rr;
    win_n   = win;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = NREQ'(1) << pick;
          lim_n   = limit_in[int'(pick)*CW +: CW];
          count_n = '0;
          win_n   = pick;
          state_n = RUN;
        end
      end
      RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
        if (!req[win]) begin
          grant_n = '0;
          rr_n    = next_ptr;
          state_n = IDLE;
        end else if (count == lim) begin
          state_n = DONE;
        end else begin
          count_n = count + CW'(1);
        end
`else
        if (count == lim) begin
          state_n = DONE;
        end else begin
          count_n = count + CW'(1);
        end
`endif
      end
      DONE: begin
        grant_n = '0;
        rr_n    = next_ptr;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
      lim   <= '0;
      rr    <= '0;
      win   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      count <= count_n;
      lim   <= lim_n;
      rr    <= rr_n;
      win   <= win_n;
    end
  end

  // done is the held grant during the single DONE cycle; busy covers RUN and DONE
  always_comb begin
    done = (state == DONE) ? grant : '0;
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_counter_share_sched.sv
// Testbench for counter_share_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an
// elapsed-time model of the scheduler.
module tb_counter_share_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;
`ifdef COUNTER_SCHED_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] limit_in = '0;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      count;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  counter_share_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .limit_in(limit_in),
    .grant(grant), .done(done), .count(count), .busy(busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
    req      = r;
    limit_in = l;
  endtask

  function automatic logic [NREQ*CW-1:0] packLim(input logic [CW-1:0] l0, input logic [CW-1:0] l1,
                                                 input logic [CW-1:0] l2, input logic [CW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic doReset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: an owner plus the number of edges elapsed since its grant
  bit m_valid = 1'b0;
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_lim   = 0;
  int m_t     = 0;
  int m_ptr   = 0;
  int m_count = 0;
  int m_w     = 0;
  bit m_found = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        m_busy  = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        m_lim   = 0;
        m_t     = 0;
      end else if (m_valid) begin
        if (!m_busy) begin
          m_found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            if (!m_found && req[(m_ptr + k) % NREQ]) begin
              m_found = 1'b1;
              m_w     = (m_ptr + k) % NREQ;
            end
          end
          if (m_found) begin
            m_owner = m_w;
            m_lim   = int'(limit_in[m_w*CW +: CW]);
            m_t     = 0;
            m_count = 0;
            m_busy  = 1'b1;
          end
        end else if (m_t <= m_lim) begin
          if (ABORT && !req[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
          end else begin
            m_t++;
            m_count = (m_t < m_lim) ? m_t : m_lim;
          end
        end else begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, on the falling edge
  initial begin
    logic [NREQ-1:0] eg;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        eg = m_busy ? (NREQ'(1) << m_owner) : '0;
        checkOutput("model_grant", grant, eg);
        checkOutput("model_done", done, (m_busy && m_t == m_lim + 1) ? eg : '0);
        checkOutput("model_count", count, m_count);
        checkOutput("model_busy", busy, m_busy);
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gcyc, maxc, ndone, wrap, prevc, cdone, nextg, g0;
    int exp_count[7] = '{0, 1, 2, 3, 3, 3, 3};

    // Reset in the middle of a RUN
    doReset();
    applyStimulus(4'b0001, packLim(8'd10, 8'd0, 8'd0, 8'd0));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant == 4'b0001 && count == 8'd5) break;
    end
    checkOutput("reset_setup_count", count, 5);
    req = '0;
    rst = 1'b1;
    tick();
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_idle_grant", grant, 0);

    // Single request, limit 3
    doReset();
    applyStimulus(4'b0001, packLim(8'd3, 8'd0, 8'd0, 8'd0));
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("single_grant", grant, (i < 5) ? 4'b0001 : 4'b0000);
      checkOutput("single_count", count, exp_count[i]);
      checkOutput("single_done", done, (i == 4) ? 4'b0001 : 4'b0000);
      checkOutput("single_busy", busy, (i < 5) ? 1 : 0);
      if (i == 4) req = '0;
    end

    // Round-robin with all requesters and zero limits
    doReset();
    applyStimulus(4'b1111, packLim(8'd0, 8'd0, 8'd0, 8'd0));
    for (int c = 0; c < 15; c++) begin
      tick();
      checkOutput("rr_grant", grant, ((c % 3) < 2) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000);
    end
    req = '0;
    tick();
    tick();
    tick();

    // Saturation at the maximum limit
    doReset();
    applyStimulus(4'b0010, packLim(8'd0, 8'd255, 8'd0, 8'd0));
    gcyc = 0; maxc = 0; ndone = 0; wrap = 0; prevc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (grant == 4'b0010) begin
        gcyc++;
        if (int'(count) < prevc) wrap++;
        prevc = int'(count);
        if (int'(count) > maxc) maxc = int'(count);
      end
      if (done == 4'b0010) begin
        ndone++;
        req = '0;
      end
      if (gcyc > 0 && grant == 4'b0000) break;
    end
    checkOutput("sat_grant_cycles", gcyc, 257);
    checkOutput("sat_max_count", maxc, 255);
    checkOutput("sat_done_pulses", ndone, 1);
    checkOutput("sat_wraps", wrap, 0);
    checkOutput("sat_count_hold", count, 255);

    // Limit is latched at grant time
    doReset();
    applyStimulus(4'b0100, packLim(8'd0, 8'd0, 8'd4, 8'd0));
    tick();
    limit_in[2*CW +: CW] = 8'd1;
    maxc = 0; cdone = -1;
    for (int i = 0; i < 20; i++) begin
      if (int'(count) > maxc) maxc = int'(count);
      if (done == 4'b0100) begin
        cdone = int'(count);
        req = '0;
        break;
      end
      tick();
    end
    checkOutput("latch_max_count", maxc, 4);
    checkOutput("latch_count_at_done", cdone, 4);
    tick();
    tick();

    // Requester 0 drops its request at count 2 while requester 1 waits
    doReset();
    applyStimulus(4'b0011, packLim(8'd6, 8'd2, 8'd0, 8'd0));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant == 4'b0001 && count == 8'd2) break;
    end
    checkOutput("abort_setup_count", count, 2);
    req = 4'b0010;
    tick();
    g0 = int'(grant);
    checkOutput("abort_grant_after_drop", g0, ABORT ? 0 : 1);
    ndone = 0; nextg = 0;
    for (int i = 0; i < 20; i++) begin
      if (done[0]) ndone++;
      if (nextg == 0 && grant != 4'b0000 && grant != 4'b0001) nextg = int'(grant);
      tick();
    end
    checkOutput("abort_done0_pulses", ndone, ABORT ? 0 : 1);
    checkOutput("abort_next_grant", nextg, 2);
    req = '0;
    tick();
    tick();

    // Randomized traffic checked by the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) begin
        if (!req[b] && $urandom_range(0, 3) == 0) req[b] = 1'b1;
        else if (req[b] && $urandom_range(0, 7) == 0) req[b] = 1'b0;
      end
      if ($urandom_range(0, 60) == 0)
        limit_in[$urandom_range(0, NREQ-1)*CW +: CW] = 8'd255;
      else
        limit_in[$urandom_range(0, NREQ-1)*CW +: CW] = CW'($urandom_range(0, 12));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
